triangle_dispatcher: RTL and testbench
======================================

Name: triangle_dispatcher

Overview:
- Upstream stage of the rasterizer. Accepts a stream of 32-bit IEEE-754 vertex words, 9 per triangle (x1,y1,z1,x2,y2,z2,x3,y3,z3), and assembles them into a small triangle FIFO.
- Presents one triangle at a time on p1/p2/p3, pulses raster_start, and waits for raster_done before dispatching the next.
- When the final triangle of a frame completes, it requests a buffer swap through a req/ack handshake with the frame-director side.

Parameters:
- DEPTH, 4, triangle FIFO depth in whole triangles; must be a power of 2 and at least 2.
- START_HOLD, 4, number of cycles raster_start is held high per triangle.
- TIMEOUT_CYCLES, 1048576, watchdog limit. Used only when DISPATCH_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock
- areset  in  1  asynchronous reset, active-low
- in_valid  in  1  vertex word valid
- in_ready  out  1  dispatcher can accept a word
- in_word  in  32  float vertex component
- in_eof  in  1  sampled on word 9 only; marks the triangle as last of frame
- p1, p2, p3  out  32 x3 each  current triangle vertices, index 0=x, 1=y, 2=z
- raster_start  out  1  start strobe to rasterizer
- raster_done  in  1  rasterizer finished current triangle
- swap_req  out  1  request front/back buffer swap
- swap_ack  in  1  swap performed (issued during vertical sync)
- busy  out  1  high when FIFO is non-empty or FSM is not IDLE
- tri_level  out  $clog2(DEPTH)+1  complete triangles in FIFO
- timeout_err  out  1  sticky watchdog flag; present only with DISPATCH_TIMEOUT_EN

Behaviour:
- Reset (areset low, asynchronous):
  - FSM goes to IDLE; FIFO pointers, word index and level are cleared.
  - p1/p2/p3 = 0; raster_start = 0; swap_req = 0; busy = 0; timeout_err = 0.
  - A partially assembled triangle is discarded.
  - in_ready = 0 while areset is low, and 1 from the first clk edge after release.
- Input handshake:
  - A word transfers when in_valid && in_ready.
  - word_idx counts 0..8 and is written directly into FIFO slot wr_ptr.
  - On the transfer with word_idx==8: in_eof is stored with the slot, wr_ptr increments, level increments, and word_idx wraps to 0.
  - in_ready = (level < DEPTH). When the FIFO is full, the stream stalls at the word boundary with no loss.
  - A partial triangle is never visible to the FSM.
- Level: a push and a pop in the same cycle leave the level unchanged. Level never exceeds DEPTH and never underflows.
- FSM:
  - IDLE: if level>0, latch the head slot into p1/p2/p3 and go to START; otherwise stay.
  - START: raster_start=1 for exactly START_HOLD cycles (counter 0..START_HOLD-1), then go to WAIT_DONE. raster_done is ignored in START.
  - WAIT_DONE: raster_start=0. When raster_done=1, pop the head (rd_ptr++, level--). If the popped eof flag is set, go to SWAP; otherwise go to IDLE.
  - SWAP: swap_req=1 is held until swap_ack=1, then swap_req drops on the next edge and the FSM returns to IDLE. Input accept continues during SWAP.
- Output stability: p1/p2/p3 are stable from the IDLE->START latch until the next latch. They are registered, with no combinational path from the FIFO.
- Latency:
  - Word 9 accepted at edge N into an empty FIFO, FSM in IDLE: p latched at edge N+1; raster_start high on cycles N+1..N+START_HOLD.
  - Back-to-back triangles: raster_done at edge M, next raster_start at edge M+2.
- Simultaneous events: raster_done and the word-9 push in the same cycle are both honoured. swap_ack outside SWAP is ignored.

Optional Feature:
- Macro: DISPATCH_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_DONE.
  - Reaching TIMEOUT_CYCLES without raster_done pops the triangle, sets timeout_err (sticky until reset), and proceeds exactly as if raster_done had arrived, including the eof->SWAP transition.
- Undefined: no counter and no timeout_err port; WAIT_DONE waits indefinitely.

Decomposition:
- gpu_pkg holds:
  - vertex_t: 3 x 32-bit float.
  - triangle_t: vertices v[3] plus eof bit.
  - dispatch_state_e: IDLE, START, WAIT_DONE, SWAP.
  - VERTEX_WORDS = 9.
- Sub-module tri_fifo: storage for triangle_t, pointers and level, with word-granular write and whole-slot pop.
- The FSM and the output registers stay in triangle_dispatcher.

Test Plan:
- Single triangle: push 42 8a 00 00 / 42 8a 00 00 / 3f 80 00 00, then (69,169,1) and (169,69,1) with eof=1 on word 9.
  -> p1 = {0x428a0000,0x428a0000,0x3f800000}, raster_start high for 4 cycles.
  -> raster_done pulse, then swap_req=1; swap_ack, then swap_req=0, FSM IDLE, busy=0.
- Backpressure: DEPTH=4, raster_done held low, push 5 triangles.
  -> in_ready=0 after the 36th word, tri_level=4.
  -> One raster_done pulse, then in_ready=1; the 5th triangle completes with data intact.
- Done ordering: assert raster_done during START -> ignored. Assert in WAIT_DONE -> pop, next start 2 cycles later. eof=0 -> no swap_req.
- Reset mid-triangle: reset after 5 words, release, push a full triangle -> first dispatched p1[0] equals the new word 0, not the stale data.
- Simultaneous push/pop: word 9 and raster_done arrive in the same cycle at level 1 -> level stays 1, no lost or duplicated triangle.
- DISPATCH_TIMEOUT_EN, TIMEOUT_CYCLES=16: never assert raster_done -> after 16 cycles in WAIT_DONE, timeout_err=1, pop, swap_req if eof was set.

Source files
------------

// File: rtl/gpu_pkg.sv
//==============================================================================
// Module   : gpu_pkg
// Brief    : Shared types for the triangle front end: vertex/triangle
//            containers, dispatcher states and vertex-word addressing helpers.
// Revision : 1.0
//==============================================================================
`default_nettype none

package gpu_pkg;

    localparam int VERTEX_WORDS = 9;

    typedef logic [31:0] float_t;

    // Component index 0 = x, 1 = y, 2 = z.
    typedef logic [2:0][31:0] vertex_t;

    typedef struct packed {
        vertex_t [2:0] v;
        logic          eof;
    } triangle_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        SWAP      = 2'd3
    } dispatch_state_e;

    // Word stream order is x1,y1,z1,x2,... so word n lands in vertex n/3.
    function automatic logic [1:0] word_vertex(input logic [3:0] idx);
        logic [1:0] v;
        if (idx < 4'd3)
            v = 2'd0;
        else if (idx < 4'd6)
            v = 2'd1;
        else
            v = 2'd2;
        return v;
    endfunction

    function automatic logic [1:0] word_comp(input logic [3:0] idx);
        logic [1:0] c;
        case (idx)
            4'd0, 4'd3, 4'd6: c = 2'd0;
            4'd1, 4'd4, 4'd7: c = 2'd1;
            default:          c = 2'd2;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/triangle_dispatcher_if.sv
//==============================================================================
// Module   : triangle_dispatcher_if
// Brief    : Valid/ready vertex-word stream into the triangle dispatcher.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface triangle_dispatcher_if;
    import gpu_pkg::*;

    logic   in_valid;
    logic   in_ready;
    float_t in_word;
    logic   in_eof;

    modport master (output in_valid, output in_word, output in_eof, input  in_ready);
    modport slave  (input  in_valid, input  in_word, input  in_eof, output in_ready);

endinterface

`default_nettype wire

// File: rtl/tri_fifo.sv
//==============================================================================
// Module   : tri_fifo
// Brief    : Triangle FIFO written one vertex word at a time and popped one
//            whole triangle at a time; only complete triangles are counted.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tri_fifo
    import gpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                    clk,
    input  wire logic                    areset,
    input  wire logic                    i_valid,
    input  wire float_t                  i_word,
    input  wire logic                    i_eof,
    output logic                         o_ready,
    input  wire logic                    i_pop,
    output triangle_t                    o_head,
    output logic [$clog2(DEPTH):0]       o_level
);

    localparam int                  c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]    c_FULL  = DEPTH[c_PTR_W:0];
    localparam logic [3:0]          c_LAST  = 4'(VERTEX_WORDS - 1);

    triangle_t            r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_level;
    logic [3:0]           r_word_idx;
    logic                 r_live;

    logic w_accept;
    logic w_last;
    logic w_push;
    logic w_pop;

    // r_live holds in_ready low until the first edge after reset release.
    assign o_ready  = r_live && (r_level < c_FULL);
    assign w_accept = i_valid && o_ready;
    assign w_last   = (r_word_idx == c_LAST);
    assign w_push   = w_accept && w_last;
    assign w_pop    = i_pop && (r_level != '0);

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_word_idx <= '0;
            r_live     <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_accept)
                r_word_idx <= w_last ? 4'd0 : r_word_idx + 4'd1;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr].v[word_vertex(r_word_idx)][word_comp(r_word_idx)] <= i_word;
            if (w_last)
                r_mem[r_wr_ptr].eof <= i_eof;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/triangle_dispatcher.sv
//==============================================================================
// Module   : triangle_dispatcher
// Brief    : Buffers assembled triangles and hands them to the rasterizer one
//            at a time, then requests a buffer swap at end of frame.
//            Optional watchdog on raster_done: define DISPATCH_TIMEOUT_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

module triangle_dispatcher
    import gpu_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int START_HOLD     = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  wire logic                 clk,
    input  wire logic                 areset,
    triangle_dispatcher_if.slave      in_if,
    output vertex_t                   p1,
    output vertex_t                   p2,
    output vertex_t                   p3,
    output logic                      raster_start,
    input  wire logic                 raster_done,
    output logic                      swap_req,
    input  wire logic                 swap_ack,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    tri_level
`ifdef DISPATCH_TIMEOUT_EN
    , output logic                    timeout_err
`endif
);

    localparam int                   c_HOLD_W    = $clog2(START_HOLD + 1);
    localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST = c_HOLD_W'(START_HOLD - 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || START_HOLD < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("triangle_dispatcher: illegal parameter combination");
    end

    dispatch_state_e        r_state;
    vertex_t                r_p1;
    vertex_t                r_p2;
    vertex_t                r_p3;
    logic                   r_raster_start;
    logic                   r_swap_req;
    logic [c_HOLD_W-1:0]    r_hold_cnt;

    triangle_t              w_head;
    logic [$clog2(DEPTH):0] w_level;
    logic                   w_done;
    logic                   w_pop;

    tri_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .areset  (areset),
        .i_valid (in_if.in_valid),
        .i_word  (in_if.in_word),
        .i_eof   (in_if.in_eof),
        .o_ready (in_if.in_ready),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_level (w_level)
    );

`ifdef DISPATCH_TIMEOUT_EN
    localparam int                 c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_timeout_err;
    logic              w_timeout;

    // A timeout is treated exactly like a raster_done for the pop and eof path.
    assign w_timeout = (r_state == WAIT_DONE) && (r_to_cnt == c_TO_LAST);
    assign w_done    = raster_done || w_timeout;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state != WAIT_DONE || w_done)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + 1'b1;
            if (w_timeout && !raster_done)
                r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_done = raster_done;
`endif

    assign w_pop = (r_state == WAIT_DONE) && w_done;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_state        <= IDLE;
            r_p1           <= '0;
            r_p2           <= '0;
            r_p3           <= '0;
            r_raster_start <= 1'b0;
            r_swap_req     <= 1'b0;
            r_hold_cnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_level != '0) begin
                        r_p1           <= w_head.v[0];
                        r_p2           <= w_head.v[1];
                        r_p3           <= w_head.v[2];
                        r_raster_start <= 1'b1;
                        r_hold_cnt     <= '0;
                        r_state        <= START;
                    end
                end
                START: begin
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        r_raster_start <= 1'b0;
                        r_state        <= WAIT_DONE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (w_done) begin
                        if (w_head.eof) begin
                            r_swap_req <= 1'b1;
                            r_state    <= SWAP;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                SWAP: begin
                    if (swap_ack) begin
                        r_swap_req <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign p1           = r_p1;
    assign p2           = r_p2;
    assign p3           = r_p3;
    assign raster_start = r_raster_start;
    assign swap_req     = r_swap_req;
    assign tri_level    = w_level;
    assign busy         = (w_level != '0) || (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_triangle_dispatcher.sv
//==============================================================================
// Module   : tb_triangle_dispatcher
// Brief    : Directed self-checking bench for triangle_dispatcher
//            (DEPTH=4, START_HOLD=4, TIMEOUT_CYCLES=16).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_triangle_dispatcher;
    import gpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic    areset;
    logic    raster_done;
    logic    swap_ack;
    vertex_t p1;
    vertex_t p2;
    vertex_t p3;
    logic    raster_start;
    logic    swap_req;
    logic    busy;
    logic [2:0] tri_level;
`ifdef DISPATCH_TIMEOUT_EN
    logic    timeout_err;
`endif

    triangle_dispatcher_if in_if ();

    triangle_dispatcher #(
        .DEPTH          (4),
        .START_HOLD     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .areset       (areset),
        .in_if        (in_if),
        .p1           (p1),
        .p2           (p2),
        .p3           (p3),
        .raster_start (raster_start),
        .raster_done  (raster_done),
        .swap_req     (swap_req),
        .swap_ack     (swap_ack),
        .busy         (busy),
        .tri_level    (tri_level)
`ifdef DISPATCH_TIMEOUT_EN
        , .timeout_err (timeout_err)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vertex_t mkv(input float_t x, input float_t y, input float_t z);
        vertex_t v;
        v[0] = x;
        v[1] = y;
        v[2] = z;
        return v;
    endfunction

    function automatic float_t tw(input int t, input int k);
        return 32'h4000_0000 | 32'(t << 8) | 32'(k);
    endfunction

    // Holds the word until in_ready is seen, then lets one edge transfer it.
    task automatic push_word(input float_t w, input logic e);
        int n;
        in_if.in_valid = 1'b1;
        in_if.in_word  = w;
        in_if.in_eof   = e;
        n = 0;
        while (!in_if.in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_if.in_ready)
            check("push_wait", 1'b0, 1'b1);
        tick();
    endtask

    task automatic push_gen(input int t, input logic e);
        for (int k = 0; k < 9; k++)
            push_word(tw(t, k), (k == 8) ? e : 1'b0);
        in_if.in_valid = 1'b0;
    endtask

    task automatic wait_start_low();
        int n = 0;
        while (raster_start && n < 20) begin
            tick();
            n++;
        end
        if (raster_start)
            check("start_low_wait", raster_start, 1'b0);
    endtask

    // Lets any pending dispatch reach WAIT_DONE, checks vertices, completes it.
    task automatic run_gen(input string tag, input int t);
        tick();
        wait_start_low();
        check({tag, "_p1"}, p1, mkv(tw(t, 0), tw(t, 1), tw(t, 2)));
        check({tag, "_p2"}, p2, mkv(tw(t, 3), tw(t, 4), tw(t, 5)));
        check({tag, "_p3"}, p3, mkv(tw(t, 6), tw(t, 7), tw(t, 8)));
        raster_done = 1'b1;
        tick();
        raster_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        float_t tv [9];
        int     hi;
        int     first;
        int     n;

        areset         = 1'b0;
        raster_done    = 1'b0;
        swap_ack       = 1'b0;
        in_if.in_valid = 1'b0;
        in_if.in_word  = '0;
        in_if.in_eof   = 1'b0;
        repeat (3) tick();

        check("rst_in_ready", in_if.in_ready, 1'b0);
        check("rst_raster_start", raster_start, 1'b0);
        check("rst_swap_req", swap_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_level", tri_level, 3'd0);
        check("rst_p1", p1, 96'd0);
`ifdef DISPATCH_TIMEOUT_EN
        check("rst_timeout_err", timeout_err, 1'b0);
`endif
        areset = 1'b1;
        check("release_in_ready_low", in_if.in_ready, 1'b0);
        tick();
        check("release_in_ready_high", in_if.in_ready, 1'b1);

        // Single end-of-frame triangle: (69,69,1) (69,169,1) (169,69,1)
        tv = '{32'h428a0000, 32'h428a0000, 32'h3f800000,
               32'h428a0000, 32'h43290000, 32'h3f800000,
               32'h43290000, 32'h428a0000, 32'h3f800000};
        for (int k = 0; k < 9; k++)
            push_word(tv[k], (k == 8));
        in_if.in_valid = 1'b0;
        check("t1_level", tri_level, 3'd1);
        check("t1_start_before", raster_start, 1'b0);
        hi    = 0;
        first = -1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (raster_start) begin
                if (first < 0)
                    first = i;
                hi++;
            end
        end
        check("t1_start_first", first, 0);
        check("t1_start_cycles", hi, 4);
        check("t1_p1", p1, mkv(32'h428a0000, 32'h428a0000, 32'h3f800000));
        check("t1_p2", p2, mkv(32'h428a0000, 32'h43290000, 32'h3f800000));
        check("t1_p3", p3, mkv(32'h43290000, 32'h428a0000, 32'h3f800000));
        check("t1_swap_before_done", swap_req, 1'b0);
        raster_done = 1'b1;
        tick();
        raster_done = 1'b0;
        check("t1_swap_req", swap_req, 1'b1);
        check("t1_level_popped", tri_level, 3'd0);
        repeat (2) tick();
        check("t1_swap_held", swap_req, 1'b1);
        check("t1_busy_in_swap", busy, 1'b1);
        swap_ack = 1'b1;
        tick();
        swap_ack = 1'b0;
        check("t1_swap_dropped", swap_req, 1'b0);
        check("t1_busy_idle", busy, 1'b0);

        // raster_done during START is ignored; in WAIT_DONE it pops
        push_gen(1, 1'b0);
        raster_done = 1'b1;
        tick();
        tick();
        raster_done = 1'b0;
        check("t2_start_high", raster_start, 1'b1);
        check("t2_done_ignored", tri_level, 3'd1);
        check("t2_a_p1", p1, mkv(tw(1, 0), tw(1, 1), tw(1, 2)));
        wait_start_low();
        push_gen(2, 1'b0);
        check("t2_level2", tri_level, 3'd2);
        raster_done = 1'b1;
        tick();
        raster_done = 1'b0;
        check("t2_pop_level", tri_level, 3'd1);
        check("t2_start_gap", raster_start, 1'b0);
        tick();
        check("t2_next_start", raster_start, 1'b1);
        run_gen("t2_b", 2);
        check("t2_no_swap", swap_req, 1'b0);
        check("t2_level0", tri_level, 3'd0);
        check("t2_busy0", busy, 1'b0);

        // Backpressure with five triangles into a four-deep FIFO
        for (int t = 3; t <= 6; t++)
            push_gen(t, 1'b0);
        check("t3_full_level", tri_level, 3'd4);
        check("t3_full_ready", in_if.in_ready, 1'b0);
        in_if.in_valid = 1'b1;
        in_if.in_word  = tw(7, 0);
        in_if.in_eof   = 1'b0;
        repeat (3) tick();
        check("t3_stalled_level", tri_level, 3'd4);
        raster_done = 1'b1;
        tick();
        raster_done = 1'b0;
        check("t3_ready_after_pop", in_if.in_ready, 1'b1);
        check("t3_level_after_pop", tri_level, 3'd3);
        push_gen(7, 1'b0);
        check("t3_refill_level", tri_level, 3'd4);
        for (int t = 4; t <= 7; t++)
            run_gen($sformatf("t3_tri%0d", t), t);
        check("t3_drained", tri_level, 3'd0);

        // Reset in the middle of a triangle discards the partial words
        for (int k = 0; k < 5; k++)
            push_word(tw(8, k), 1'b0);
        in_if.in_valid = 1'b0;
        areset = 1'b0;
        #1;
        check("t4_reset_ready", in_if.in_ready, 1'b0);
        tick();
        areset = 1'b1;
        tick();
        push_gen(9, 1'b0);
        check("t4_level", tri_level, 3'd1);
        run_gen("t4_new", 9);
        check("t4_level0", tri_level, 3'd0);

        // Word-9 push and raster_done in the same cycle at level 1
        push_gen(10, 1'b0);
        tick();
        wait_start_low();
        check("t5_level_pre", tri_level, 3'd1);
        check("t5_c_p1", p1, mkv(tw(10, 0), tw(10, 1), tw(10, 2)));
        for (int k = 0; k < 8; k++)
            push_word(tw(11, k), 1'b0);
        in_if.in_word  = tw(11, 8);
        in_if.in_eof   = 1'b0;
        in_if.in_valid = 1'b1;
        raster_done    = 1'b1;
        tick();
        in_if.in_valid = 1'b0;
        raster_done    = 1'b0;
        check("t5_level_same", tri_level, 3'd1);
        run_gen("t5_d", 11);
        repeat (3) tick();
        check("t5_no_duplicate", raster_start, 1'b0);
        check("t5_level0", tri_level, 3'd0);

`ifdef DISPATCH_TIMEOUT_EN
        // Watchdog: no raster_done ever arrives
        push_gen(12, 1'b1);
        tick();
        wait_start_low();
        check("t6_err_before", timeout_err, 1'b0);
        n = 0;
        while (tri_level != 3'd0 && n < 40) begin
            tick();
            n++;
        end
        check("t6_cycles", n, 16);
        check("t6_timeout_err", timeout_err, 1'b1);
        check("t6_swap_req", swap_req, 1'b1);
        swap_ack = 1'b1;
        tick();
        swap_ack = 1'b0;
        check("t6_swap_drop", swap_req, 1'b0);
        tick();
        check("t6_err_sticky", timeout_err, 1'b1);
`else
        n = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
